// File: rtl/m107_pkg.sv
// m107_pkg
// Shared types and constants for the CPU-side SDRAM bridge.
//   cpu_line_t     : one 64-bit cache line viewed as four 16-bit CPU words
//   bridge_state_t : bridge FSM states
//   CPU_LINE_BYTES : bytes held by one cache line
//   merge_bytes()  : byte-enable merge of a CPU write into a stored word
package m107_pkg;

  localparam int CPU_LINE_BYTES = 8;
  localparam int CPU_LINE_WORDS = CPU_LINE_BYTES / 2;
  localparam int CPU_WORD_SEL_W = $clog2(CPU_LINE_WORDS);

  // Word 0 occupies line bits [15:0], word 3 occupies bits [63:48].
  typedef logic [CPU_LINE_WORDS-1:0][15:0] cpu_line_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2
  } bridge_state_t;

  // be[0] selects the low byte, be[1] the high byte.
  function automatic logic [15:0] merge_bytes(input logic [15:0] oldWord,
                                              input logic [15:0] newWord,
                                              input logic [1:0]  be);
    logic [15:0] merged;
    merged[7:0]  = be[0] ? newWord[7:0]  : oldWord[7:0];
    merged[15:8] = be[1] ? newWord[15:8] : oldWord[15:8];
    return merged;
  endfunction

endpackage

// File: rtl/cpu_line_cache.sv
// cpu_line_cache
// Single-line read cache: one tag, one valid bit and one 64-bit line.
// Provides hit detection, word selection and the byte-merge used by
// write-through hits.
// Ports:
//   clk, reset      : clock and asynchronous active-high reset
//   invalidate_i    : clears the valid bit and forces lookups to miss
//   lookupTag_i     : tag of the address currently presented by the CPU
//   wordSel_i       : word of the stored line to present on word_o
//   fillEn_i        : load fillLine_i/fillTag_i, valid <= fillValid_i
//   fillValid_i     : valid bit to store along with the fill
//   fillTag_i       : tag of the line being filled
//   fillLine_i      : line returned by the SDRAM controller
//   mergeEn_i       : CPU write cycle; bytes merge only if the line hits
//   mergeBe_i       : byte enables of the write
//   mergeData_i     : write data
//   hit_o           : lookup hit
//   word_o          : selected word of the stored line
module cpu_line_cache
  import m107_pkg::*;
#(
  parameter int TAG_W = 22
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      invalidate_i,
  input  logic [TAG_W-1:0]          lookupTag_i,
  input  logic [CPU_WORD_SEL_W-1:0] wordSel_i,
  input  logic                      fillEn_i,
  input  logic                      fillValid_i,
  input  logic [TAG_W-1:0]          fillTag_i,
  input  cpu_line_t                 fillLine_i,
  input  logic                      mergeEn_i,
  input  logic [1:0]                mergeBe_i,
  input  logic [15:0]               mergeData_i,
  output logic                      hit_o,
  output logic [15:0]               word_o
);

  logic             valid_q;
  logic [TAG_W-1:0] tag_q;
  cpu_line_t        line_q;

  // An invalidate in the same cycle as a lookup must turn a hit into a miss,
  // so it gates the hit directly rather than waiting for valid_q to clear.
  assign hit_o  = valid_q && (tag_q == lookupTag_i) && !invalidate_i;
  assign word_o = line_q[wordSel_i];

  // Line storage. A fill replaces the whole line; a write hit merges only the
  // enabled bytes. Invalidate overrides the valid bit last so it always wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      line_q  <= '0;
    end else begin
      if (fillEn_i) begin
        line_q  <= fillLine_i;
        tag_q   <= fillTag_i;
        valid_q <= fillValid_i;
      end else if (mergeEn_i && hit_o) begin
        line_q[wordSel_i] <= merge_bytes(line_q[wordSel_i], mergeData_i, mergeBe_i);
      end
      if (invalidate_i) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cpu_sdram_bridge.sv
// cpu_sdram_bridge
// Turns CPU RAM/ROM memory cycles into toggle-handshake requests on the CPU
// port of the SDRAM controller. Reads are served from a single-line cache
// when possible; writes are write-through and dropped for read-only regions.
// Ports:
//   clk, reset     : clock and asynchronous active-high reset
//   cpu_req        : one-cycle strobe starting a CPU cycle
//   cpu_we/be/dout : write flag, byte enables, write data
//   ram_rom_memrq  : cycle targets RAM/ROM
//   writable       : region accepts writes
//   sdr_addr       : SDRAM byte address of the cycle
//   invalidate     : clears the cache
//   cpu_din        : registered read data to the CPU
//   cpu_ready      : low while the CPU must wait
//   sdr_cpu_*      : SDRAM controller request/acknowledge port
module cpu_sdram_bridge
  import m107_pkg::*;
#(
  parameter int LINE_TAG_W = 22
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_be,
  input  logic [15:0] cpu_dout,
  input  logic        ram_rom_memrq,
  input  logic        writable,
  input  logic [24:0] sdr_addr,
  input  logic        invalidate,
  output logic [15:0] cpu_din,
  output logic        cpu_ready,
  output logic [24:0] sdr_cpu_addr,
  output logic        sdr_cpu_req,
  input  logic        sdr_cpu_ack,
  output logic        sdr_cpu_wr,
  output logic [1:0]  sdr_cpu_be,
  output logic [15:0] sdr_cpu_din,
  input  logic [63:0] sdr_cpu_dout
);

  bridge_state_t             state_q;
  logic                      cpuReady_q;
  logic [15:0]               cpuDin_q;
  logic                      sdrReq_q;
  logic                      sdrWr_q;
  logic [1:0]                sdrBe_q;
  logic [24:0]               sdrAddr_q;
  logic [15:0]               sdrDin_q;
  logic [CPU_WORD_SEL_W-1:0] fillWord_q;
  logic                      fillKilled_q;

  logic        cpuCycle;
  logic        ackMatch;
  logic        fillEn;
  logic        fillValid;
  logic        mergeEn;
  logic        cacheHit;
  logic [15:0] cacheWord;
  cpu_line_t   fillLine;
  logic        unusedAddrLsb;

  // Byte addresses, 16-bit words: bit 0 never selects anything here.
  assign unusedAddrLsb = sdr_addr[0];

  assign cpuCycle  = cpu_req && ram_rom_memrq && (state_q == IDLE);
  assign ackMatch  = (sdr_cpu_ack == sdrReq_q);
  assign fillEn    = (state_q == READ_WAIT) && ackMatch;
  // An invalidate seen at any point during the fill leaves the line invalid.
  assign fillValid = !(fillKilled_q || invalidate);
  assign mergeEn   = cpuCycle && cpu_we && writable;
  assign fillLine  = sdr_cpu_dout;

  cpu_line_cache #(
    .TAG_W(LINE_TAG_W)
  ) u_cache (
    .clk         (clk),
    .reset       (reset),
    .invalidate_i(invalidate),
    .lookupTag_i (sdr_addr[3 +: LINE_TAG_W]),
    .wordSel_i   (sdr_addr[2:1]),
    .fillEn_i    (fillEn),
    .fillValid_i (fillValid),
    .fillTag_i   (sdrAddr_q[3 +: LINE_TAG_W]),
    .fillLine_i  (fillLine),
    .mergeEn_i   (mergeEn),
    .mergeBe_i   (cpu_be),
    .mergeData_i (cpu_dout),
    .hit_o       (cacheHit),
    .word_o      (cacheWord)
  );

  // Bridge FSM with registered CPU and SDRAM outputs. SDRAM-side registers
  // are only written when a request is launched, so they hold steady while
  // it is outstanding; cpu_req outside IDLE is simply not looked at.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cpuReady_q   <= 1'b1;
      cpuDin_q     <= '0;
      sdrReq_q     <= 1'b0;
      sdrWr_q      <= 1'b0;
      sdrBe_q      <= '0;
      sdrAddr_q    <= '0;
      sdrDin_q     <= '0;
      fillWord_q   <= '0;
      fillKilled_q <= 1'b0;
    end else begin
      if (invalidate) begin
        fillKilled_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (cpuCycle) begin
            if (cpu_we) begin
              if (writable) begin
                sdrAddr_q  <= sdr_addr;
                sdrWr_q    <= 1'b1;
                sdrBe_q    <= cpu_be;
                sdrDin_q   <= cpu_dout;
                sdrReq_q   <= ~sdrReq_q;
                cpuReady_q <= 1'b0;
                state_q    <= WRITE_WAIT;
              end
            end else if (cacheHit) begin
              cpuDin_q <= cacheWord;
            end else begin
              // Launching a fresh fill: earlier invalidates are already
              // reflected in valid_q and must not kill this line.
              sdrAddr_q    <= {sdr_addr[24:3], 3'b000};
              sdrWr_q      <= 1'b0;
              sdrReq_q     <= ~sdrReq_q;
              fillWord_q   <= sdr_addr[2:1];
              fillKilled_q <= 1'b0;
              cpuReady_q   <= 1'b0;
              state_q      <= READ_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (ackMatch) begin
            cpuDin_q   <= fillLine[fillWord_q];
            cpuReady_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        WRITE_WAIT: begin
          if (ackMatch) begin
            cpuReady_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          cpuReady_q <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign cpu_din      = cpuDin_q;
  assign cpu_ready    = cpuReady_q;
  assign sdr_cpu_addr = sdrAddr_q;
  assign sdr_cpu_req  = sdrReq_q;
  assign sdr_cpu_wr   = sdrWr_q;
  assign sdr_cpu_be   = sdrBe_q;
  assign sdr_cpu_din  = sdrDin_q;

endmodule

// File: tb/tb_cpu_sdram_bridge.sv
// tb_cpu_sdram_bridge
// Directed self-checking bench for cpu_sdram_bridge. Expected read data is
// queued when a read is issued and compared when the bridge completes it;
// the SDRAM acknowledge is driven by the bench as a toggle.
module tb_cpu_sdram_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_be;
  logic [15:0] cpu_dout;
  logic        ram_rom_memrq;
  logic        writable;
  logic [24:0] sdr_addr;
  logic        invalidate;
  logic [15:0] cpu_din;
  logic        cpu_ready;
  logic [24:0] sdr_cpu_addr;
  logic        sdr_cpu_req;
  logic        sdr_cpu_ack;
  logic        sdr_cpu_wr;
  logic [1:0]  sdr_cpu_be;
  logic [15:0] sdr_cpu_din;
  logic [63:0] sdr_cpu_dout;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] expQ[$];
  logic        expReq;

  localparam logic [63:0] LINE_A = 64'h4444_3333_2222_1111;
  localparam logic [63:0] LINE_B = 64'h8888_7777_6666_5555;

  always #5 clk = ~clk;

  cpu_sdram_bridge #(
    .LINE_TAG_W(22)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_be       (cpu_be),
    .cpu_dout     (cpu_dout),
    .ram_rom_memrq(ram_rom_memrq),
    .writable     (writable),
    .sdr_addr     (sdr_addr),
    .invalidate   (invalidate),
    .cpu_din      (cpu_din),
    .cpu_ready    (cpu_ready),
    .sdr_cpu_addr (sdr_cpu_addr),
    .sdr_cpu_req  (sdr_cpu_req),
    .sdr_cpu_ack  (sdr_cpu_ack),
    .sdr_cpu_wr   (sdr_cpu_wr),
    .sdr_cpu_be   (sdr_cpu_be),
    .sdr_cpu_din  (sdr_cpu_din),
    .sdr_cpu_dout (sdr_cpu_dout)
  );

  // All driving and sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One CPU cycle: strobe cpu_req for a single clock; address/data stay put.
  task automatic applyStimulus(input logic we, input logic [1:0] be,
                               input logic [15:0] data, input logic [24:0] addr,
                               input logic wrOk, input logic memrq);
    cpu_we        = we;
    cpu_be        = be;
    cpu_dout      = data;
    sdr_addr      = addr;
    writable      = wrOk;
    ram_rom_memrq = memrq;
    cpu_req       = 1'b1;
    tick();
    cpu_req       = 1'b0;
  endtask

  task automatic popCheck(input string tag);
    if (expQ.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected <empty scoreboard>", tag, cpu_din);
    end else begin
      checkOutput(tag, cpu_din, expQ.pop_front());
    end
  endtask

  // SDRAM controller answer: present the line and flip the acknowledge.
  task automatic ackWith(input logic [63:0] line);
    sdr_cpu_dout = line;
    sdr_cpu_ack  = ~sdr_cpu_ack;
    tick();
    sdr_cpu_dout = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " ready"}, cpu_ready, 1'b1);
    checkOutput({tag, " cpu_din"}, cpu_din, 16'h0000);
    checkOutput({tag, " req"}, sdr_cpu_req, 1'b0);
    checkOutput({tag, " wr"}, sdr_cpu_wr, 1'b0);
    checkOutput({tag, " be"}, sdr_cpu_be, 2'b00);
    checkOutput({tag, " addr"}, sdr_cpu_addr, 25'h0);
    checkOutput({tag, " sdr din"}, sdr_cpu_din, 16'h0000);
  endtask

  initial begin
    reset         = 1'b1;
    cpu_req       = 1'b0;
    cpu_we        = 1'b0;
    cpu_be        = 2'b00;
    cpu_dout      = 16'h0000;
    ram_rom_memrq = 1'b0;
    writable      = 1'b0;
    sdr_addr      = 25'h0;
    invalidate    = 1'b0;
    sdr_cpu_ack   = 1'b0;
    sdr_cpu_dout  = 64'h0;
    expReq        = 1'b0;
    tick();
    tick();
    checkResetValues("reset");
    reset = 1'b0;
    tick();

    // Cold read miss, acknowledged 5 cycles after the request.
    expQ.push_back(16'h3333);
    applyStimulus(1'b0, 2'b00, 16'h0, 25'h0001234, 1'b1, 1'b1);
    expReq = ~expReq;
    checkOutput("miss1 addr", sdr_cpu_addr, 25'h0001230);
    checkOutput("miss1 req", sdr_cpu_req, expReq);
    checkOutput("miss1 wr", sdr_cpu_wr, 1'b0);
    checkOutput("miss1 ready low", cpu_ready, 1'b0);
    repeat (4) tick();
    checkOutput("miss1 still waiting", cpu_ready, 1'b0);
    checkOutput("miss1 addr stable", sdr_cpu_addr, 25'h0001230);
    ackWith(LINE_A);
    checkOutput("miss1 ready back", cpu_ready, 1'b1);
    popCheck("miss1 data");

    // Hit on the same line, other word.
    expQ.push_back(16'h4444);
    applyStimulus(1'b0, 2'b00, 16'h0, 25'h0001236, 1'b1, 1'b1);
    checkOutput("hit ready", cpu_ready, 1'b1);
    checkOutput("hit no toggle", sdr_cpu_req, expReq);
    popCheck("hit data");

    // Write-through low byte, with a stray cpu_req during WRITE_WAIT.
    applyStimulus(1'b1, 2'b01, 16'hABCD, 25'h0001232, 1'b1, 1'b1);
    expReq = ~expReq;
    checkOutput("wr req", sdr_cpu_req, expReq);
    checkOutput("wr wr", sdr_cpu_wr, 1'b1);
    checkOutput("wr be", sdr_cpu_be, 2'b01);
    checkOutput("wr addr", sdr_cpu_addr, 25'h0001232);
    checkOutput("wr data", sdr_cpu_din, 16'hABCD);
    checkOutput("wr ready low", cpu_ready, 1'b0);
    tick();
    applyStimulus(1'b1, 2'b11, 16'h1111, 25'h0005678, 1'b1, 1'b1);
    checkOutput("stray addr stable", sdr_cpu_addr, 25'h0001232);
    checkOutput("stray data stable", sdr_cpu_din, 16'hABCD);
    checkOutput("stray be stable", sdr_cpu_be, 2'b01);
    checkOutput("stray req stable", sdr_cpu_req, expReq);
    checkOutput("stray ready low", cpu_ready, 1'b0);
    ackWith(64'h0);
    checkOutput("wr ready back", cpu_ready, 1'b1);
    expQ.push_back(16'h22CD);
    applyStimulus(1'b0, 2'b00, 16'h0, 25'h0001232, 1'b1, 1'b1);
    checkOutput("merged hit no toggle", sdr_cpu_req, expReq);
    popCheck("merged data");

    // Write to a read-only region is dropped.
    applyStimulus(1'b1, 2'b11, 16'h5555, 25'h0001234, 1'b0, 1'b1);
    checkOutput("ro ready", cpu_ready, 1'b1);
    checkOutput("ro no toggle", sdr_cpu_req, expReq);
    expQ.push_back(16'h3333);
    applyStimulus(1'b0, 2'b00, 16'h0, 25'h0001234, 1'b1, 1'b1);
    popCheck("ro unchanged data");

    // Non-RAM cycle is ignored.
    applyStimulus(1'b0, 2'b00, 16'h0, 25'h0009000, 1'b1, 1'b0);
    checkOutput("nonram ready", cpu_ready, 1'b1);
    checkOutput("nonram no toggle", sdr_cpu_req, expReq);
    checkOutput("nonram din held", cpu_din, 16'h3333);

    // Invalidate during READ_WAIT: data still returned, line left invalid.
    expQ.push_back(16'h5555);
    applyStimulus(1'b0, 2'b00, 16'h0, 25'h0002000, 1'b1, 1'b1);
    expReq = ~expReq;
    checkOutput("inv miss req", sdr_cpu_req, expReq);
    checkOutput("inv miss addr", sdr_cpu_addr, 25'h0002000);
    tick();
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    ackWith(LINE_B);
    checkOutput("inv ready back", cpu_ready, 1'b1);
    popCheck("inv fill data");
    expQ.push_back(16'h6666);
    applyStimulus(1'b0, 2'b00, 16'h0, 25'h0002002, 1'b1, 1'b1);
    expReq = ~expReq;
    checkOutput("reread misses", cpu_ready, 1'b0);
    checkOutput("reread req", sdr_cpu_req, expReq);
    ackWith(LINE_B);
    popCheck("reread data");

    // Reset while a read is outstanding.
    applyStimulus(1'b0, 2'b00, 16'h0, 25'h0003000, 1'b1, 1'b1);
    expReq = ~expReq;
    checkOutput("abandon req", sdr_cpu_req, expReq);
    tick();
    reset       = 1'b1;
    sdr_cpu_ack = 1'b0;
    expReq      = 1'b0;
    expQ.delete();
    tick();
    checkResetValues("midreset");
    reset = 1'b0;
    tick();
    expQ.push_back(16'h3333);
    applyStimulus(1'b0, 2'b00, 16'h0, 25'h0001234, 1'b1, 1'b1);
    expReq = ~expReq;
    checkOutput("post reset miss", cpu_ready, 1'b0);
    checkOutput("post reset req", sdr_cpu_req, expReq);
    checkOutput("post reset addr", sdr_cpu_addr, 25'h0001230);
    ackWith(LINE_A);
    checkOutput("post reset ready", cpu_ready, 1'b1);
    popCheck("post reset data");

    // Invalidate together with a would-be hit forces a miss.
    expQ.push_back(16'h4444);
    invalidate = 1'b1;
    applyStimulus(1'b0, 2'b00, 16'h0, 25'h0001236, 1'b1, 1'b1);
    invalidate = 1'b0;
    expReq = ~expReq;
    checkOutput("inv+hit misses", cpu_ready, 1'b0);
    checkOutput("inv+hit req", sdr_cpu_req, expReq);
    ackWith(LINE_A);
    checkOutput("inv+hit ready", cpu_ready, 1'b1);
    popCheck("inv+hit data");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_sdram_bridge.md
# cpu_sdram_bridge

Converts V33 CPU memory cycles that the address translator has routed to RAM/ROM into requests on the CPU port of the SDRAM controller. It sits between the address translator and the SDRAM controller. A single 64-bit line read cache lets sequential instruction fetches complete without an SDRAM round trip. Writes are write-through; writes to read-only regions are dropped.

## Interface
Parameters:
- `LINE_TAG_W`, 22: tag width. It covers `sdr_addr[24:3]`.

Ports:
- `clk`  in  1  system clock; every register is clocked on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  one-cycle strobe that starts a CPU memory cycle.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_be`  in  2  byte enables; [0] is the low byte.
- `cpu_dout`  in  16  CPU write data.
- `ram_rom_memrq`  in  1  cycle targets RAM/ROM (from the translator).
- `writable`  in  1  region is writable (from the translator).
- `sdr_addr`  in  25  SDRAM byte address (from the translator).
- `invalidate`  in  1  clears the cache (ROM download, bank change).
- `cpu_din`  out  16  read data returned to the CPU.
- `cpu_ready`  out  1  0 = insert CPU wait states.
- `sdr_cpu_addr`  out  25  request address. For reads it is line-aligned, with [2:0] = 0.
- `sdr_cpu_req`  out  1  toggle-type request.
- `sdr_cpu_ack`  in  1  toggle-type acknowledge.
- `sdr_cpu_wr`  out  1  request is a write.
- `sdr_cpu_be`  out  2  write byte enables.
- `sdr_cpu_din`  out  16  write data sent to the SDRAM.
- `sdr_cpu_dout`  in  64  read line. It is valid in the cycle the acknowledge matches the request.

## Operation
- States are `IDLE`, `READ_WAIT` and `WRITE_WAIT`. There is one line register, one tag register and one valid bit.
- Requests with `ram_rom_memrq` = 0 are ignored: no state change, and `cpu_ready` stays 1.
- A write with `writable` = 0 is dropped. It causes no SDRAM access and no cache change.
- Read hit: the cache is valid and `tag == sdr_addr[24:3]`. The word at `sdr_addr[2:1]` (word 0 = line bits [15:0]) goes to `cpu_din`, and the state stays `IDLE`.
- Read miss:
  - Set `sdr_cpu_addr = {sdr_addr[24:3],3'b0}` and `sdr_cpu_wr` = 0, toggle `sdr_cpu_req`, and enter `READ_WAIT`.
  - When `sdr_cpu_ack == sdr_cpu_req`, latch the line and the tag, set valid, drive the selected word on `cpu_din`, and return to `IDLE`.
- Write:
  - Set `sdr_cpu_addr = sdr_addr`, `sdr_cpu_wr` = 1, `sdr_cpu_be = cpu_be` and `sdr_cpu_din = cpu_dout`. Toggle the request and enter `WRITE_WAIT`.
  - If the cache hits, merge the enabled bytes into the line in the same cycle.
  - When the acknowledge matches, return to `IDLE`.
- `invalidate` clears the valid bit in every state. If it arrives during `READ_WAIT`, the fill data is still returned to the CPU, but the valid bit remains 0.
- `cpu_req` while the state is not `IDLE` is a protocol violation. It is ignored and must not corrupt the cycle in flight.

## Timing
- Reset values:
  - `cpu_ready` = 1, `cpu_din` = 0.
  - `sdr_cpu_req` = 0, `sdr_cpu_wr` = 0, `sdr_cpu_be` = 0, `sdr_cpu_addr` = 0, `sdr_cpu_din` = 0.
  - State = `IDLE`, valid = 0, tag = 0.
- Reset mid-operation abandons the access. The SDRAM controller shares `reset`, so its acknowledge also returns to 0.
- Hit, dropped write and non-RAM cycles:
  - `cpu_ready` stays 1 with zero wait states.
  - For a hit, `cpu_din` is registered and valid on the cycle after `cpu_req` (latency 1).
- Miss or write:
  - `cpu_ready` falls on the cycle after `cpu_req`, and `sdr_cpu_req` toggles on that same edge.
  - `cpu_ready` rises on the cycle after the acknowledge matches. For a read, `cpu_din` is valid in that same cycle.
- All SDRAM-side outputs stay stable while a request is outstanding.
- If `invalidate` and a hit-qualifying `cpu_req` arrive in the same cycle, the access is treated as a miss.

## Structure
- `m107_pkg` gains:
  - `cpu_line_t` (a 64-bit line viewed as 4×16-bit words).
  - A `bridge_state_t` enum.
  - `CPU_LINE_BYTES = 8`.
- One sub-module, `cpu_line_cache`. It holds the tag, valid and line storage and provides:
  - hit detection,
  - word select,
  - the byte-merge write.
- The FSM and the toggle handshake live in `cpu_sdram_bridge`.

## Test plan
- Reset, then read `sdr_addr` 0x0001234 → miss.
  - `sdr_cpu_addr` = 0x0001230 and `sdr_cpu_req` = 1.
  - Acknowledge after 5 cycles with line 0x4444_3333_2222_1111 → `cpu_din` = 0x3333 and `cpu_ready` returns to 1.
- Next read at 0x0001236 → hit.
  - No request toggle; `cpu_din` = 0x4444 one cycle later, with `cpu_ready` held at 1.
- Write 0xABCD with `be` = 01 at 0x0001232 with `writable` = 1.
  - SDRAM request has `wr` = 1 and `be` = 01.
  - After the acknowledge, a read at 0x0001232 hits and returns 0x22CD.
- Write with `writable` = 0 → no toggle on `sdr_cpu_req`, `cpu_ready` held at 1, and a subsequent read returns the unchanged data.
- `invalidate` during `READ_WAIT` → the CPU still receives the fill word, and a re-read of the same line misses.
- Assert `reset` while in `READ_WAIT` → all outputs return to reset values; the next read is a miss with `sdr_cpu_req` = 1.
